egress_port_arbiter: RTL and testbench

//  Output (egress) side of one switch port: the far end of the per-port input FIFOs.

---
 rtl/egress_port_arbiter.sv | 110 +++++++++++
 tb/tb_egress_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/egress_port_arbiter.sv
// Egress side of one switch port: round-robin pop from the input FIFOs
// whose head targets this port, registered valid/ready output stage.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req_i      per-FIFO request (non-empty and head targets this port)
//   pkt_i      packed head packets, FIFO i at [i*PKT_W +: PKT_W]
//   gnt_o      combinational one-hot pop strobe
//   valid_out  output register holds a packet
//   ready_out  sink accepts the held packet this cycle
//   pkt_out    registered packet
//   src_out    index of the FIFO the packet came from
//   pkt_cnt    saturating count of delivered packets
//   stall_err  sticky flag: packet unaccepted for STALL_MAX cycles
module egress_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PKT_W     = 16,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 1024,
    localparam int SRC_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req_i,
    input  logic [NUM_PORTS*PKT_W-1:0] pkt_i,
    output logic [NUM_PORTS-1:0]       gnt_o,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [PKT_W-1:0]           pkt_out,
    output logic [SRC_W-1:0]           src_out,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic                       stall_err
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    logic [SRC_W-1:0]   rr_ptr;
    logic [STALL_W-1:0] stall_cnt;
    logic               load_en;
    logic               grant;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   cand_idx;
    int                 cand;

    assign load_en = !valid_out || ready_out;

    // Search starts one past the last winner; first requester wins.
    always_comb begin
        gnt_o    = '0;
        grant    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        if (!rst && load_en) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand     = (int'(rr_ptr) + k) % NUM_PORTS;
                cand_idx = SRC_W'(cand);
                if (!grant && req_i[cand_idx]) begin
                    grant = 1'b1;
                    win   = cand_idx;
                end
            end
        end
        if (grant) begin
            gnt_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            pkt_out   <= '0;
            src_out   <= '0;
            rr_ptr    <= SRC_W'(NUM_PORTS - 1);
        end else if (grant) begin
            valid_out <= 1'b1;
            pkt_out   <= pkt_i[int'(win)*PKT_W +: PKT_W];
            src_out   <= win;
            rr_ptr    <= win;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (valid_out && ready_out && !(&pkt_cnt)) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    // Error fires on the edge where the count of stalled cycles hits STALL_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (valid_out && !ready_out) begin
            if (stall_cnt != STALL_W'(STALL_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_cnt >= STALL_W'(STALL_MAX - 1)) begin
                stall_err <= 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_egress_port_arbiter.sv
// Directed bench for egress_port_arbiter: reset, single request,
// round-robin, backpressure, stall flag, counter saturation.
module tb_egress_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_i;
    logic [63:0] pkt_i;
    logic [3:0]  gnt_o;
    logic        valid_out;
    logic        ready_out;
    logic [15:0] pkt_out;
    logic [1:0]  src_out;
    logic [3:0]  pkt_cnt;
    logic        stall_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    egress_port_arbiter #(
        .NUM_PORTS(4),
        .PKT_W    (16),
        .CNT_W    (4),
        .STALL_MAX(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .pkt_i    (pkt_i),
        .gnt_o    (gnt_o),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .pkt_out  (pkt_out),
        .src_out  (src_out),
        .pkt_cnt  (pkt_cnt),
        .stall_err(stall_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_i     = 4'hF;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) pkt_i[i*16 +: 16] = 16'hB000 + 16'(i);

        // 1 reset
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_cnt", 32'(pkt_cnt), 32'h0);
        chk("rst_err", 32'(stall_err), 32'h0);
        chk("rst_pkt", 32'(pkt_out), 32'h0);
        chk("rst_src", 32'(src_out), 32'h0);
        rst   = 1'b0;
        req_i = 4'b0100;
        pkt_i[2*16 +: 16] = 16'hA5C3;

        // 2 single request
        #1;
        chk("single_gnt", 32'(gnt_o), 32'h4);
        tick();
        chk("single_valid", 32'(valid_out), 32'h1);
        chk("single_pkt", 32'(pkt_out), 32'hA5C3);
        chk("single_src", 32'(src_out), 32'h2);
        req_i = 4'b0000;
        pkt_i[2*16 +: 16] = 16'hB002;
        #1;
        chk("single_idle_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk("single_drain_valid", 32'(valid_out), 32'h0);
        chk("single_cnt", 32'(pkt_cnt), 32'h1);

        // 3 round-robin from reset
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        req_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt_o), 32'(4'b0001 << (i % 4)));
            tick();
            chk("rr_src", 32'(src_out), 32'(i % 4));
            chk("rr_pkt", 32'(pkt_out), 32'h0000B000 + 32'(i % 4));
        end
        req_i = 4'h0;
        tick();
        chk("rr_cnt", 32'(pkt_cnt), 32'd8);
        chk("rr_valid", 32'(valid_out), 32'h0);

        // 4 backpressure; last grant was 3
        req_i = 4'b0010;
        #1;
        chk("bp_gnt", 32'(gnt_o), 32'h2);
        tick();
        chk("bp_valid", 32'(valid_out), 32'h1);
        ready_out = 1'b0;
        req_i     = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_gnt", 32'(gnt_o), 32'h0);
            tick();
            chk("bp_hold_pkt", 32'(pkt_out), 32'hB001);
            chk("bp_hold_src", 32'(src_out), 32'h1);
            chk("bp_hold_valid", 32'(valid_out), 32'h1);
        end
        chk("bp_no_err", 32'(stall_err), 32'h0);
        ready_out = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(gnt_o), 32'h4);
        tick();
        chk("bp_cnt", 32'(pkt_cnt), 32'd9);
        chk("bp_next_src", 32'(src_out), 32'h2);
        chk("bp_next_pkt", 32'(pkt_out), 32'hB002);

        // 5 stall flag
        ready_out = 1'b0;
        req_i     = 4'h0;
        for (int i = 0; i < 7; i++) tick();
        chk("stall_7", 32'(stall_err), 32'h0);
        tick();
        chk("stall_8", 32'(stall_err), 32'h1);
        ready_out = 1'b1;
        tick();
        chk("stall_sticky", 32'(stall_err), 32'h1);
        chk("stall_cnt", 32'(pkt_cnt), 32'd10);
        chk("stall_valid", 32'(valid_out), 32'h0);
        tick();
        chk("stall_sticky2", 32'(stall_err), 32'h1);
        rst = 1'b1;
        tick();
        chk("stall_rst", 32'(stall_err), 32'h0);
        rst = 1'b0;

        // 6 saturation and mid-traffic reset
        req_i = 4'hF;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_15", 32'(pkt_cnt), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 32'(pkt_cnt), 32'hF);
        chk("sat_valid", 32'(valid_out), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(valid_out), 32'h0);
        chk("mid_rst_cnt", 32'(pkt_cnt), 32'h0);
        chk("mid_rst_pkt", 32'(pkt_out), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
